// File: rtl/term_cursor_ctrl.sv
// Cursor/command sequencer for the terminal character RAM: owns the cursor,
// scrolls by rotating top_row, and drives the RAM's single write port.
module term_cursor_ctrl #(
  parameter int TERM_W = 70,
  parameter int TERM_H = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk_50M,
  input  logic              clrn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_char,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] cursor_idx,
  output logic [4:0]        top_row
);

  localparam int COL_W = $clog2(TERM_W);
  localparam logic [1:0] OP_PUTC      = 2'd0;
  localparam logic [1:0] OP_NEWLINE   = 2'd1;
  localparam logic [1:0] OP_BACKSPACE = 2'd2;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(TERM_W - 1);
  localparam logic [4:0]        ROW_LAST = 5'(TERM_H - 1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(TERM_W);
  localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(TERM_W * TERM_H);

  typedef enum logic [1:0] {IDLE, CHAR_THEN_CLR, CLR_LINE, CLR_ALL} state_t;

  state_t             state_reg;
  logic [4:0]         cur_row_reg;
  logic [COL_W-1:0]   cur_col_reg;
  logic [ADDR_W-1:0]  clr_base_reg;
  logic [ADDR_W-1:0]  clr_cnt_reg;

  logic [5:0]         prow_sum;
  logic [5:0]         prow;
  logic [4:0]         top_inc;
  logic [ADDR_W-1:0]  top_base;
  logic [ADDR_W-1:0]  clr_lim;
  logic               at_bottom;

  // Physical row is a conditional subtract, never a modulo.
  assign prow_sum   = {1'b0, top_row} + {1'b0, cur_row_reg};
  assign prow       = (prow_sum >= 6'(TERM_H)) ? prow_sum - 6'(TERM_H) : prow_sum;
  assign cursor_idx = ADDR_W'(prow) * W_A + ADDR_W'(cur_col_reg);
  assign top_inc    = (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;
  assign top_base   = ADDR_W'(top_row) * W_A;
  assign clr_lim    = (state_reg == CLR_ALL) ? CELLS_A : W_A;
  assign at_bottom  = (cur_row_reg == ROW_LAST);
  assign cmd_ready  = (state_reg == IDLE);

  always_ff @(posedge clk_50M or negedge clrn) begin
    if (!clrn) begin
      state_reg    <= IDLE;
      cur_row_reg  <= '0;
      cur_col_reg  <= '0;
      top_row      <= '0;
      clr_base_reg <= '0;
      clr_cnt_reg  <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wr_en <= 1'b0;
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUTC: begin
                wr_en   <= 1'b1;
                wr_addr <= cursor_idx;
                wr_data <= cmd_char;
                if (cur_col_reg == COL_LAST) begin
                  cur_col_reg <= '0;
                  if (!at_bottom) begin
                    cur_row_reg <= cur_row_reg + 5'd1;
                  end else begin
                    // Char write goes out first; the old top row is cleared after.
                    top_row      <= top_inc;
                    clr_base_reg <= top_base;
                    state_reg    <= CHAR_THEN_CLR;
                  end
                end else begin
                  cur_col_reg <= cur_col_reg + COL_W'(1);
                end
              end
              OP_NEWLINE: begin
                cur_col_reg <= '0;
                if (!at_bottom) begin
                  cur_row_reg <= cur_row_reg + 5'd1;
                end else begin
                  top_row     <= top_inc;
                  wr_en       <= 1'b1;
                  wr_addr     <= top_base;
                  wr_data     <= 8'h00;
                  clr_cnt_reg <= ADDR_W'(1);
                  state_reg   <= CLR_LINE;
                end
              end
              OP_BACKSPACE: begin
                if (cur_col_reg != '0) begin
                  cur_col_reg <= cur_col_reg - COL_W'(1);
                  wr_en       <= 1'b1;
                  wr_addr     <= cursor_idx - ADDR_W'(1);
                  wr_data     <= 8'h00;
                end else if (cur_row_reg != '0) begin
                  // At column 0 the previous cell is idx-1, except when wrapping physical row 0.
                  cur_row_reg <= cur_row_reg - 5'd1;
                  cur_col_reg <= COL_LAST;
                  wr_en       <= 1'b1;
                  wr_addr     <= (prow == 6'd0) ? CELLS_A - ADDR_W'(1) : cursor_idx - ADDR_W'(1);
                  wr_data     <= 8'h00;
                end
              end
              default: begin
                cur_row_reg <= '0;
                cur_col_reg <= '0;
                top_row     <= '0;
                wr_en       <= 1'b1;
                wr_addr     <= '0;
                wr_data     <= 8'h00;
                clr_cnt_reg <= ADDR_W'(1);
                state_reg   <= CLR_ALL;
              end
            endcase
          end
        end
        CHAR_THEN_CLR: begin
          wr_en       <= 1'b1;
          wr_addr     <= clr_base_reg;
          wr_data     <= 8'h00;
          clr_cnt_reg <= ADDR_W'(1);
          state_reg   <= CLR_LINE;
        end
        default: begin
          // clr_cnt_reg counts writes already issued; the last one is still on the bus.
          if (clr_cnt_reg == clr_lim) begin
            wr_en     <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wr_addr     <= wr_addr + ADDR_W'(1);
            clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_cursor_ctrl.sv
// Directed bench for term_cursor_ctrl: a vector table for single-cycle
// commands plus hand-written scroll, wrap-scroll, clear and abort sequences.
module tb_term_cursor_ctrl;

  logic        clk_50M = 1'b0;
  logic        clrn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_char = 8'h00;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] cursor_idx;
  logic [4:0]  top_row;

  term_cursor_ctrl #(.TERM_W(70), .TERM_H(30), .ADDR_W(12)) dut (
    .clk_50M    (clk_50M),
    .clrn       (clrn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_char   (cmd_char),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_idx (cursor_idx),
    .top_row    (top_row)
  );

  always #5 clk_50M = ~clk_50M;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  ch;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    logic [11:0] exp_cur;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] ch);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
    step();
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] addr, input logic [7:0] data,
                        input logic rdy);
    chk({tag, " wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(addr));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(data));
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'(rdy));
  endtask

  initial begin
    //        valid op    ch     wr    addr   data   cursor
    vecs[0]  = '{1'b1, 2'd0, 8'h41, 1'b1, 12'd0,   8'h41, 12'd1};
    vecs[1]  = '{1'b0, 2'd0, 8'h99, 1'b0, 12'd0,   8'h00, 12'd1};
    vecs[2]  = '{1'b1, 2'd2, 8'h00, 1'b1, 12'd0,   8'h00, 12'd0};
    vecs[3]  = '{1'b1, 2'd2, 8'h00, 1'b0, 12'd0,   8'h00, 12'd0};
    vecs[4]  = '{1'b1, 2'd0, 8'h42, 1'b1, 12'd0,   8'h42, 12'd1};
    vecs[5]  = '{1'b1, 2'd1, 8'h00, 1'b0, 12'd0,   8'h00, 12'd70};
    vecs[6]  = '{1'b1, 2'd2, 8'h00, 1'b1, 12'd69,  8'h00, 12'd69};
    vecs[7]  = '{1'b1, 2'd0, 8'h43, 1'b1, 12'd69,  8'h43, 12'd70};
    vecs[8]  = '{1'b1, 2'd0, 8'h44, 1'b1, 12'd70,  8'h44, 12'd71};
    vecs[9]  = '{1'b1, 2'd1, 8'hFF, 1'b0, 12'd0,   8'h00, 12'd140};
    vecs[10] = '{1'b1, 2'd2, 8'h00, 1'b1, 12'd139, 8'h00, 12'd139};
    vecs[11] = '{1'b1, 2'd2, 8'h55, 1'b1, 12'd138, 8'h00, 12'd138};

    do_reset();

    // Table: one command (or idle cycle) per clock, checked in cycle k+1.
    for (int i = 0; i < 12; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_char  = vecs[i].ch;
      step();
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vecs[i].exp_data));
      end
      chk($sformatf("vec%0d cursor_idx", i), 32'(cursor_idx), 32'(vecs[i].exp_cur));
      chk($sformatf("vec%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
      chk($sformatf("vec%0d top_row", i), 32'(top_row), 32'd0);
      $display("vec %0d op=%0d ch=%02h wr_en=%0d addr=%0d data=%02h cursor=%0d",
               i, vecs[i].op, vecs[i].ch, wr_en, wr_addr, wr_data, cursor_idx);
    end
    cmd_valid = 1'b0;

    // Reset values with non-zero state beforehand.
    clrn = 1'b0;
    #1;
    chk("rst wr_en", 32'(wr_en), 32'd0);
    step();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst cursor_idx", 32'(cursor_idx), 32'd0);
    chk("rst top_row", 32'(top_row), 32'd0);
    $display("reset: ready=%0d wr_en=%0d cursor=%0d top=%0d", cmd_ready, wr_en, cursor_idx, top_row);
    clrn = 1'b1;
    step();

    // Row wrap: 70 back-to-back PUTCs, no stall.
    for (int i = 0; i < 70; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_char  = 8'h61;
      step();
      chk_wr($sformatf("rowwrap%0d", i), 12'(i), 8'h61, 1'b1);
    end
    cmd_valid = 1'b0;
    chk("rowwrap cursor_idx", 32'(cursor_idx), 32'd70);
    chk("rowwrap top_row", 32'(top_row), 32'd0);
    $display("row wrap: cursor=%0d top=%0d", cursor_idx, top_row);

    // Scroll via NEWLINE from the bottom row.
    do_reset();
    for (int i = 0; i < 29; i++) send(2'd1, 8'h00);
    chk("scroll pre cursor_idx", 32'(cursor_idx), 32'd2030);
    send(2'd1, 8'h00);
    chk("scroll top_row", 32'(top_row), 32'd1);
    chk("scroll cursor_idx", 32'(cursor_idx), 32'd0);
    for (int i = 0; i < 70; i++) begin
      chk_wr($sformatf("scroll%0d", i), 12'(i), 8'h00, 1'b0);
      step();
    end
    chk("scroll end cmd_ready", 32'(cmd_ready), 32'd1);
    chk("scroll end wr_en", 32'(wr_en), 32'd0);
    $display("scroll: top=%0d cursor=%0d ready=%0d", top_row, cursor_idx, cmd_ready);

    // Wrap-scroll: PUTC at (29,69).
    do_reset();
    for (int i = 0; i < 29; i++) send(2'd1, 8'h00);
    for (int i = 0; i < 69; i++) send(2'd0, 8'h62);
    chk("wscroll pre cursor_idx", 32'(cursor_idx), 32'd2099);
    send(2'd0, 8'h5A);
    chk_wr("wscroll char", 12'd2099, 8'h5A, 1'b0);
    step();
    for (int i = 0; i < 70; i++) begin
      chk_wr($sformatf("wscroll%0d", i), 12'(i), 8'h00, 1'b0);
      step();
    end
    chk("wscroll end cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wscroll end wr_en", 32'(wr_en), 32'd0);
    chk("wscroll top_row", 32'(top_row), 32'd1);
    chk("wscroll cursor_idx", 32'(cursor_idx), 32'd0);
    $display("wrap-scroll: top=%0d cursor=%0d", top_row, cursor_idx);

    // Full clear from a non-zero cursor and top_row.
    send(2'd0, 8'h63);
    chk("clr pre cursor_idx", 32'(cursor_idx), 32'd1);
    send(2'd3, 8'h00);
    chk("clr cursor_idx", 32'(cursor_idx), 32'd0);
    chk("clr top_row", 32'(top_row), 32'd0);
    for (int i = 0; i < 2100; i++) begin
      chk_wr($sformatf("clr%0d", i), 12'(i), 8'h00, 1'b0);
      step();
    end
    chk("clr end cmd_ready", 32'(cmd_ready), 32'd1);
    chk("clr end wr_en", 32'(wr_en), 32'd0);
    $display("clear: 2100 writes, ready=%0d", cmd_ready);

    // Clear aborted by reset at the 500th write.
    send(2'd0, 8'h64);
    send(2'd0, 8'h65);
    chk("abort pre cursor_idx", 32'(cursor_idx), 32'd2);
    send(2'd3, 8'h00);
    for (int i = 0; i < 500; i++) begin
      chk_wr($sformatf("abort%0d", i), 12'(i), 8'h00, 1'b0);
      if (i < 499) step();
    end
    clrn = 1'b0;
    #1;
    chk("abort wr_en async", 32'(wr_en), 32'd0);
    chk("abort cmd_ready async", 32'(cmd_ready), 32'd1);
    step();
    step();
    clrn = 1'b1;
    step();
    chk("abort post cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort post wr_en", 32'(wr_en), 32'd0);
    chk("abort post cursor_idx", 32'(cursor_idx), 32'd0);
    chk("abort post top_row", 32'(top_row), 32'd0);
    $display("abort: ready=%0d wr_en=%0d cursor=%0d top=%0d", cmd_ready, wr_en, cursor_idx, top_row);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/term_cursor_ctrl.md
# term_cursor_ctrl

Command sequencer for the terminal text buffer. It takes character-level commands (put char, newline, backspace, clear) over a valid/ready handshake and drives the single write port of the term character RAM. It owns the cursor and implements scrolling as a circular row offset (`top_row`), so scrolling never copies RAM. The display side reads `top_row` and `cursor_idx` to map screen rows to physical RAM rows and to draw the blinking cursor.

## Interface
- `TERM_W`, 70: characters per row.
- `TERM_H`, 30: rows.
- `ADDR_W`, 12: RAM address width; must satisfy TERM_W*TERM_H ≤ 2^ADDR_W.

Ports:
- `clk_50M`  in  1  system clock.
- `clrn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block accepts a command this cycle.
- `cmd_op`  in  2  command code: 0 PUTC, 1 NEWLINE, 2 BACKSPACE, 3 CLEAR.
- `cmd_char`  in  8  ASCII code; used by PUTC only.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  physical RAM index.
- `wr_data`  out  8  byte to write.
- `cursor_idx`  out  ADDR_W  physical RAM index of the cursor.
- `top_row`  out  5  physical row shown at screen row 0.

## Operation
- Logical cursor state: `cur_row` in 0..TERM_H-1, `cur_col` in 0..TERM_W-1.
- Physical row: `prow = top_row + cur_row`, minus TERM_H if the sum is ≥ TERM_H. No divider.
- `cursor_idx = prow*TERM_W + cur_col`, combinational from registers. The multiply is by a constant.
- FSM states:
  - IDLE
  - CHAR_THEN_CLR: one cycle; flushes a pending char write before a scroll.
  - CLR_LINE: writes TERM_W zeros.
  - CLR_ALL: writes TERM_W*TERM_H zeros.
- `cmd_ready = (state==IDLE)`. A command is accepted on an edge where `cmd_valid && cmd_ready`.
- PUTC:
  - Writes `cmd_char` at `cursor_idx`, then advances `cur_col`.
  - At `cur_col==TERM_W-1`, it wraps: `cur_col` becomes 0 and newline logic applies.
- NEWLINE:
  - Sets `cur_col` to 0.
  - If `cur_row < TERM_H-1`, increments `cur_row`.
  - Otherwise it scrolls:
    - `top_row` increments, wrapping from TERM_H-1 to 0.
    - `cur_row` stays at TERM_H-1.
    - The physical row equal to the old `top_row` (the new bottom row) is cleared in CLR_LINE.
- BACKSPACE:
  - If `cur_col > 0`: decrement `cur_col`, then write 0 at the new index.
  - Else if `cur_row > 0`: `cur_row--`, `cur_col = TERM_W-1`, then write 0 there.
  - At (0,0): accepted with no write and no state change.
- CLEAR:
  - Writes 0 to physical indices 0..TERM_W*TERM_H-1 in ascending order.
  - Cursor and `top_row` are zeroed at accept.
- `cmd_char` is ignored for ops other than PUTC. Commands are never dropped; the block only stalls by deasserting `cmd_ready`.
- Reset values: `cmd_ready` 1, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `cursor_idx` 0, `top_row` 0, state IDLE. Reset does not clear RAM contents.
- `clrn` low mid-clear: the operation aborts, `wr_en` drops immediately (async), and all registers return to reset values.

## Timing
- Let k be the accept edge. `wr_en`/`wr_addr`/`wr_data` are registered and valid during cycle k+1.
- Cursor registers and `top_row` update at edge k, so `cursor_idx` reflects the new position in cycle k+1.
- PUTC or BACKSPACE without scroll:
  - One write in cycle k+1.
  - `cmd_ready` stays high, so back-to-back accepts are allowed every cycle.
- NEWLINE with scroll:
  - Clear writes in cycles k+1..k+TERM_W, addresses `old_top*TERM_W + 0..TERM_W-1`.
  - `cmd_ready` is low in those cycles and high again in cycle k+TERM_W+1.
- PUTC causing wrap plus scroll:
  - Char write in cycle k+1 (CHAR_THEN_CLR).
  - Clear writes in cycles k+2..k+TERM_W+1.
  - `cmd_ready` is low in k+1..k+TERM_W+1.
- CLEAR: writes in cycles k+1..k+TERM_W*TERM_H; `cmd_ready` is low for that whole span.
- `wr_en` is high for exactly one cycle per written cell; `wr_addr` increments by 1 per clear cycle.

## Test plan
- **Single PUTC:** release `clrn`, then PUTC 0x41. Expect one `wr_en` pulse, `wr_addr` 0, `wr_data` 0x41. `cursor_idx` becomes 1 and `cmd_ready` stays 1.
- **Row wrap:** 70 back-to-back PUTC 0x61. Expect writes at addresses 0..69, one per cycle, with no stall. Final `cursor_idx` is 70 and `top_row` stays 0.
- **Backspace:** with the cursor at row 1, col 0, BACKSPACE writes 0x00 to address 69 and `cursor_idx` becomes 69. A second BACKSPACE after reset at (0,0) produces no `wr_en` and `cursor_idx` stays 0.
- **Scroll:** move to row 29, col 0 (29 NEWLINEs, `cursor_idx` 2030), then NEWLINE. Expect `top_row` 1, `cmd_ready` low for 70 cycles, zeros written to addresses 0..69, and final `cursor_idx` ((1+29) mod 30)*70 = 0.
- **Wrap-scroll:** at row 29, col 69 with `top_row` 0, PUTC 0x5A. Expect address 2099 written with 0x5A in cycle k+1, then addresses 0..69 zeroed, `cmd_ready` low for 71 cycles, and `top_row` 1.
- **Clear and abort:** CLEAR produces 2100 writes to addresses 0..2099 and then `cmd_ready` 1. A second CLEAR with `clrn` pulsed low at the 500th write drops `wr_en` at once; after release, `cmd_ready` is 1 and `cursor_idx`/`top_row` are 0.
